// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU command encodings, sequencer states and settle default.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] cADD  = 3'd0;
  localparam logic [2:0] cSUB  = 3'd1;
  localparam logic [2:0] cXOR  = 3'd2;
  localparam logic [2:0] cSLT  = 3'd3;
  localparam logic [2:0] cAND  = 3'd4;
  localparam logic [2:0] cNAND = 3'd5;
  localparam logic [2:0] cNOR  = 3'd6;
  localparam logic [2:0] cOR   = 3'd7;

  // 2300-unit ALU settle plus zero-flag NOR at a 100-unit clock period.
  localparam int SETTLE_CYCLES_DEF = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Brief    : Loadable down-counter; expire flags the last edge of the window.
// Revision : 1.0
// ============================================================================
module settle_timer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign expire = (r_count == CNT_W'(1)) && !load;

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Issue/capture stage holding ALU operands for a settle window.
// Revision : 1.0
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_over,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carry,
  output logic        out_over,
  output logic        out_zero,
  output logic [15:0] ops_done
);

  localparam int               CNT_W         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_drain;
  logic        w_expire;
  logic        w_capture;

  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_sel;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_carry;
  logic        r_out_over;
  logic        r_out_zero;
  logic [15:0] r_ops_done;

  assign w_in_ready = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_drain    = r_out_valid && out_ready;
  assign w_capture  = (r_state == SETTLE) && w_expire;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_accept),
    .value  (c_SETTLE_LOAD),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETTLE;
      SETTLE:  if (w_expire) w_next = HOLD;
      HOLD:    if (w_drain)  w_next = w_accept ? SETTLE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands only move on accept so the ALU sees stable inputs all window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else if (w_accept) begin
      r_alu_a   <= in_a;
      r_alu_b   <= in_b;
      r_alu_sel <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_over   <= 1'b0;
      r_out_zero   <= 1'b0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_carry  <= alu_carry;
      r_out_over   <= alu_over;
      r_out_zero   <= alu_zero;
    end else if (w_drain) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops_done <= '0;
    end else if (w_drain) begin
      r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign in_ready   = w_in_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_over   = r_out_over;
  assign out_zero   = r_out_zero;
  assign ops_done   = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench: transaction model plus directed vectors.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int S0 = 24;
  localparam int S1 = 1;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_ready, out_valid, out_carry, out_over, out_zero;
  logic [31:0] alu_a, alu_b, out_result, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_carry, alu_over, alu_zero;
  logic [15:0] ops_done;

  logic        d1_in_valid = 1'b0, d1_out_ready = 1'b0;
  logic [31:0] d1_in_a = '0, d1_in_b = '0;
  logic [2:0]  d1_in_op = '0;
  logic        d1_in_ready, d1_out_valid, d1_out_carry, d1_out_over, d1_out_zero;
  logic [31:0] d1_alu_a, d1_alu_b, d1_out_result, d1_alu_result;
  logic [2:0]  d1_alu_sel;
  logic        d1_alu_carry, d1_alu_over, d1_alu_zero;
  logic [15:0] d1_ops_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_q[$];

  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, o;
    c = 1'b0; o = 1'b0; s = '0; r = '0;
    case (op)
      cADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      cSUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      cXOR:  r = a ^ b;
      cSLT:  r = {31'd0, ($signed(a) < $signed(b))};
      cAND:  r = a & b;
      cNAND: r = ~(a & b);
      cNOR:  r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, o, (r == 32'd0), r};
  endfunction

  assign {alu_carry, alu_over, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_sel);
  assign {d1_alu_carry, d1_alu_over, d1_alu_zero, d1_alu_result} =
      alu_ref(d1_alu_a, d1_alu_b, d1_alu_sel);

  alu_sequencer #(.SETTLE_CYCLES(S0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_over(alu_over), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_over(out_over), .out_zero(out_zero), .ops_done(ops_done)
  );

  alu_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_a(d1_in_a), .in_b(d1_in_b), .in_op(d1_in_op),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_sel(d1_alu_sel),
    .alu_result(d1_alu_result), .alu_carry(d1_alu_carry), .alu_over(d1_alu_over),
    .alu_zero(d1_alu_zero), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_result(d1_out_result), .out_carry(d1_out_carry), .out_over(d1_out_over),
    .out_zero(d1_out_zero), .ops_done(d1_ops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model of the dut instance: one op in flight at most,
  // result appears SETTLE edges after accept, leaves when downstream takes it.
  logic        m_pending = 1'b0, m_out_valid = 1'b0;
  int          m_cap = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]  m_op = '0;
  logic        m_c = 1'b0, m_o = 1'b0, m_z = 1'b0;
  logic [15:0] m_ops = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pending = 1'b0; m_out_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0;
        m_res = '0; m_c = 1'b0; m_o = 1'b0; m_z = 1'b0; m_ops = '0;
        if (clk) cyc++;
      end else begin
        logic drain, acc;
        cyc++;
        drain = m_out_valid && out_ready;
        acc   = in_valid && (!m_pending || drain);
        if (drain) begin
          m_out_valid = 1'b0; m_pending = 1'b0; m_ops = m_ops + 16'd1;
        end
        if (m_pending && !m_out_valid && cyc == m_cap) begin
          {m_c, m_o, m_z, m_res} = alu_ref(m_a, m_b, m_op);
          m_out_valid = 1'b1;
        end
        if (acc) begin
          m_a = in_a; m_b = in_b; m_op = in_op; m_pending = 1'b1; m_cap = cyc + S0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
      check("in_ready",   in_ready,   !m_pending || (m_out_valid && out_ready));
      check("out_valid",  out_valid,  m_out_valid);
      check("ops_done",   ops_done,   m_ops);
      check("alu_a",      alu_a,      m_a);
      check("alu_b",      alu_b,      m_b);
      check("alu_sel",    alu_sel,    m_op);
      check("out_result", out_result, m_res);
      check("out_carry",  out_carry,  m_c);
      check("out_over",   out_over,   m_o);
      check("out_zero",   out_zero,   m_z);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: in_ready got 0 want 1 within 100 cycles");
    end
    @(posedge clk); #2;
  endtask

  task automatic wait_valid(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin at_cyc = cyc; break; end
    end
    if (at_cyc < 0) begin
      n_checks++; n_errors++;
      $display("FAIL wait_valid_timeout: out_valid got 0 want 1 within 60 cycles");
    end
  endtask

  initial begin
    int t, a0, n0;
    logic [15:0] ops0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ops_done", ops_done, 16'h0000);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;

    // ADD overflow; downstream stalled until the result is there
    issue(32'h7FFF_FFFF, 32'h0000_0001, cADD);
    in_valid = 1'b0;
    a0 = acc_q[$];
    wait_valid(t);
    check("add_latency", 32'(t - a0), 32'd24);
    check("add_result", out_result, 32'h8000_0000);
    check("add_over", out_over, 1'b1);
    check("add_carry", out_carry, 1'b0);
    check("add_zero", out_zero, 1'b0);
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    check("add_ops", ops_done, 16'd1);

    // SUB to zero, then 10 cycles of backpressure
    issue(32'h5, 32'h5, cSUB);
    in_valid = 1'b0;
    wait_valid(t);
    check("sub_result", out_result, 32'h0);
    check("sub_zero", out_zero, 1'b1);
    check("sub_carry", out_carry, 1'b1);
    check("sub_over", out_over, 1'b0);
    repeat (10) @(negedge clk);
    check("bp_result", out_result, 32'h0);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_ops", ops_done, 16'd1);
    @(posedge clk); #2 out_ready = 1'b1;
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, cAND);
    in_valid = 1'b0;
    check("same_edge_ops", ops_done, 16'd2);
    wait_valid(t);
    check("and_result", out_result, 32'hF000_F000);
    @(posedge clk); #2;
    check("and_ops", ops_done, 16'd3);

    // Back-to-back with downstream always ready
    n0 = acc_q.size();
    ops0 = ops_done;
    for (int i = 0; i < 5; i++)
      issue(32'h1234_5678 + 32'(i), 32'h8765_4321 ^ 32'(i), 3'(i + 2));
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("b2b_ops", ops_done, ops0 + 16'd5);
    for (int i = 1; i < 5; i++)
      check("b2b_spacing", 32'(acc_q[n0 + i] - acc_q[n0 + i - 1]), 32'd25);

    // Reset in the middle of the settle window
    issue(32'h1, 32'h2, cADD);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 32'h0);
    check("mid_rst_alu_b", alu_b, 32'h0);
    check("mid_rst_ops", ops_done, 16'h0);
    check("mid_rst_valid", out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_ops", ops_done, 16'h0);

    // Single-cycle settle window and ops_done wrap on the second instance
    @(posedge clk); #2;
    d1_in_a = 32'hFFFF_0000; d1_in_b = 32'h0F0F_0F0F; d1_in_op = cXOR; d1_in_valid = 1'b1;
    @(negedge clk);
    check("d1_idle_ready", d1_in_ready, 1'b1);
    @(posedge clk); #2 d1_in_valid = 1'b0;
    @(negedge clk);
    check("d1_not_yet", d1_out_valid, 1'b0);
    @(negedge clk);
    check("d1_valid", d1_out_valid, 1'b1);
    check("d1_result", d1_out_result, 32'hF0F0_0F0F);
    check("d1_hold_ready", d1_in_ready, 1'b0);
    force dut1.r_ops_done = 16'hFFFE;
    @(posedge clk); #2 release dut1.r_ops_done;
    check("d1_preload", d1_ops_done, 16'hFFFE);
    d1_out_ready = 1'b1;
    @(posedge clk); #2;
    check("d1_ops_ffff", d1_ops_done, 16'hFFFF);
    check("d1_drained", d1_out_valid, 1'b0);
    d1_in_a = 32'h0000_00F0; d1_in_b = 32'h0000_000F; d1_in_op = cOR; d1_in_valid = 1'b1;
    @(posedge clk); #2 d1_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("d1_ops_wrap", d1_ops_done, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
